twenty_bit_down_timer: RTL and testbench

Loadable, pausable down-counting timer. It is the consumer-side counterpart of the free-running up-counter tick generator. Game logic loads a duration, starts it, and waits on a one-cycle `done` strobe at terminal count, with optional auto-reload for periodic events. It sits between the game FSM (move/food/respawn delays) and the rest of the datapath, and runs entirely in the `clock` domain.

---
 rtl/twenty_bit_down_timer_pkg.sv | 12 +
 rtl/twenty_bit_down_timer_if.sv | 27 ++
 rtl/twenty_bit_down_timer_start_edge_detect.sv | 22 ++
 rtl/twenty_bit_down_timer.sv | 69 ++++++
 tb/tb_twenty_bit_down_timer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/twenty_bit_down_timer_pkg.sv
// rtl/twenty_bit_down_timer_pkg.sv - shared constants and FSM state type for the down timer
package twenty_bit_down_timer_pkg;

  localparam int DEFAULT_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/twenty_bit_down_timer_if.sv
// rtl/twenty_bit_down_timer_if.sv - control/status bundle between game FSM and down timer
interface twenty_bit_down_timer_if
  import twenty_bit_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             stop;
  logic             pause;
  logic             reload_en;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, reload_en, load_value,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, pause, reload_en, load_value,
    output count, busy, done
  );

endinterface

// File: rtl/twenty_bit_down_timer_start_edge_detect.sv
// rtl/twenty_bit_down_timer_start_edge_detect.sv - rising-edge detector on the start level
module twenty_bit_down_timer_start_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic start_edge
);

  logic start_q;

  // Preset high so a start level already asserted across reset is not seen as an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start;
    end
  end

  assign start_edge = start & ~start_q;

endmodule

// File: rtl/twenty_bit_down_timer.sv
// rtl/twenty_bit_down_timer.sv - loadable, pausable down timer with terminal-count strobe and auto-reload
module twenty_bit_down_timer
  import twenty_bit_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  twenty_bit_down_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_r;
  logic             count_zero;
  logic             start_edge;

  twenty_bit_down_timer_start_edge_detect u_start_edge_detect (
    .clock      (clock),
    .reset      (reset),
    .start      (bus.start),
    .start_edge (start_edge)
  );

  assign count_zero = (count_r == '0);

  // Priority: reset, stop, start edge, terminal count, pause, decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count_r <= '0;
    end else if (bus.stop) begin
      state <= IDLE;
    end else if (start_edge) begin
      count_r <= bus.load_value;
      state   <= RUN;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (count_zero) begin
            if (bus.reload_en) begin
              count_r <= bus.load_value;
            end else begin
              state <= IDLE;
            end
          end else if (bus.pause) begin
            state <= HOLD;
          end else begin
            count_r <= count_r - ONE;
          end
        end
        HOLD: begin
          // Resuming costs one cycle with no decrement.
          if (!bus.pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.count = count_r;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == RUN) && count_zero && !bus.stop;

endmodule

// File: tb/tb_twenty_bit_down_timer.sv
// tb/tb_twenty_bit_down_timer.sv - table-driven scoreboard bench for the down timer
module tb_twenty_bit_down_timer;
  import twenty_bit_down_timer_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  logic clock = 1'b0;
  logic reset = 1'b1;

  twenty_bit_down_timer_if #(.WIDTH(W)) bus ();

  twenty_bit_down_timer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         start;
    logic         stop;
    logic         pause;
    logic         reload_en;
    logic [W-1:0] load_value;
    logic [W-1:0] exp_count;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  typedef struct {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    int           tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic s, input logic st, input logic p, input logic r,
                              input logic [W-1:0] lv, input logic [W-1:0] ec,
                              input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.stop = st; v.pause = p; v.reload_en = r; v.load_value = lv;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  function automatic void add(input logic s, input logic st, input logic p, input logic r,
                              input logic [W-1:0] lv, input logic [W-1:0] ec,
                              input logic eb, input logic ed);
    vecs.push_back(mk(s, st, p, r, lv, ec, eb, ed));
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s tag=%0d actual=%0h expected=%0h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.start      = v.start;
    bus.stop       = v.stop;
    bus.pause      = v.pause;
    bus.reload_en  = v.reload_en;
    bus.load_value = v.load_value;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", -1, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("count", e.tag, 32'(bus.count), 32'(e.count));
      chk("busy",  e.tag, 32'(bus.busy),  32'(e.busy));
      chk("done",  e.tag, 32'(bus.done),  32'(e.done));
    end
  endtask

  task automatic step(input vec_t v, input int tag);
    exp_t e;
    drive(v);
    e.count = v.exp_count;
    e.busy  = v.exp_busy;
    e.done  = v.exp_done;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // start held high through reset release
    add(1,0,0,0,5, 0,0,0); add(1,0,0,0,5, 0,0,0); add(0,0,0,0,5, 0,0,0);
    // basic run, N=3
    add(1,0,0,0,3, 3,1,0); add(0,0,0,0,3, 2,1,0); add(0,0,0,0,3, 1,1,0);
    add(0,0,0,0,3, 0,1,1); add(0,0,0,0,3, 0,0,0); add(0,0,0,0,3, 0,0,0);
    // load_value change mid-run is ignored
    add(1,0,0,0,4, 4,1,0); add(0,0,0,0,9, 3,1,0); add(0,0,0,0,9, 2,1,0);
    add(0,1,0,0,9, 2,0,0);
    // auto-reload, N=2, five periods then stop
    add(1,0,0,1,2, 2,1,0);
    for (int p = 0; p < 5; p++) begin
      add(0,0,0,1,2, 1,1,0); add(0,0,0,1,2, 0,1,1); add(0,0,0,1,2, 2,1,0);
    end
    add(0,0,0,1,2, 1,1,0); add(0,1,0,1,2, 1,0,0); add(0,0,0,1,2, 1,0,0);
    // reload with N=0 keeps done high
    add(1,0,0,1,0, 0,1,1); add(0,0,0,1,0, 0,1,1); add(0,0,0,1,0, 0,1,1);
    add(0,0,0,1,0, 0,1,1); add(0,1,0,1,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    // pause 4 cycles at count 3
    add(1,0,0,0,5, 5,1,0); add(0,0,0,0,5, 4,1,0); add(0,0,0,0,5, 3,1,0);
    for (int p = 0; p < 4; p++) add(0,0,1,0,5, 3,1,0);
    add(0,0,0,0,5, 3,1,0); add(0,0,0,0,5, 2,1,0); add(0,0,0,0,5, 1,1,0);
    add(0,0,0,0,5, 0,1,1); add(0,0,0,0,5, 0,0,0);
    // N=0: done after E0, terminal acted on despite pause
    add(1,0,0,0,0, 0,1,1); add(0,0,1,0,0, 0,0,0);
    // restart mid-run, then stop/start priority
    add(1,0,0,0,5, 5,1,0); add(0,0,0,0,5, 4,1,0); add(0,0,0,0,5, 3,1,0);
    add(0,0,0,0,5, 2,1,0); add(1,0,0,0,7, 7,1,0); add(0,0,0,0,7, 6,1,0);
    add(0,1,0,0,7, 6,0,0); add(1,1,0,0,7, 6,0,0); add(1,0,0,0,7, 6,0,0);
    add(0,0,0,0,7, 6,0,0);
    // restart at terminal count discards the terminal action
    add(1,0,0,0,1, 1,1,0); add(0,0,0,0,1, 0,1,1); add(1,0,0,0,4, 4,1,0);
    add(0,1,0,0,4, 4,0,0); add(0,0,0,0,4, 4,0,0);
    // restart from HOLD
    add(1,0,0,0,3, 3,1,0); add(0,0,1,0,3, 3,1,0); add(1,0,1,0,8, 8,1,0);
    add(0,0,0,0,8, 7,1,0); add(0,1,0,0,8, 7,0,0); add(0,0,0,0,8, 7,0,0);
    // full-width load value
    add(1,0,0,0,MAXV, MAXV,1,0); add(0,0,0,0,MAXV, MAXV-1,1,0);
    add(0,1,0,0,MAXV, MAXV-1,0,0); add(0,0,0,0,MAXV, MAXV-1,0,0);

    bus.start = 1'b1; bus.stop = 1'b0; bus.pause = 1'b0; bus.reload_en = 1'b0;
    bus.load_value = 5;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_count", 0, 32'(bus.count), 32'd0);
    chk("reset_busy",  0, 32'(bus.busy),  32'd0);
    chk("reset_done",  0, 32'(bus.done),  32'd0);
    chk("reset_state", 0, 32'(dut.state), 32'(IDLE));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // stop during the terminal-count cycle masks done immediately
    step(mk(1,0,0,0,1, 1,1,0), 1000);
    step(mk(0,0,0,0,1, 0,1,1), 1001);
    bus.stop = 1'b1;
    #1;
    chk("done_masked_by_stop", 1002, 32'(bus.done), 32'd0);
    chk("busy_before_stop_edge", 1002, 32'(bus.busy), 32'd1);
    step(mk(0,1,0,0,1, 0,0,0), 1003);
    step(mk(0,0,0,0,1, 0,0,0), 1004);

    // reset mid-run at count 4
    step(mk(1,0,0,0,6, 6,1,0), 2000);
    step(mk(0,0,0,0,6, 5,1,0), 2001);
    step(mk(0,0,0,0,6, 4,1,0), 2002);
    reset = 1'b1;
    step(mk(0,0,0,0,6, 0,0,0), 2003);
    chk("midrun_reset_state", 2003, 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    step(mk(0,0,0,0,6, 0,0,0), 2004);
    step(mk(1,0,0,0,2, 2,1,0), 2005);
    step(mk(0,0,0,0,2, 1,1,0), 2006);
    step(mk(0,1,0,0,2, 1,0,0), 2007);

    chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
